// File: rtl/instr_fetch.sv
// instr_fetch: FRiscV instruction fetch stage.
// Holds the program counter, issues word-aligned requests on a pipelined
// instruction-memory port, buffers returned words with their PC in a small
// FIFO and hands them to decode over valid/ready. A redirect flushes the
// buffer, drops in-flight responses and restarts fetch at the target.
module instr_fetch #(
    parameter int              ARCH       = 32,
    parameter logic [ARCH-1:0] RESET_ADDR = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk_in,
    input  logic            rstn_in,
    output logic            imem_req_out,
    output logic [ARCH-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [ARCH-1:0] imem_rdata_in,
    input  logic            redirect_in,
    input  logic [ARCH-1:0] redirect_addr_in,
    output logic [ARCH-1:0] instr_out,
    output logic [ARCH-1:0] pc_out,
    output logic            valid_out,
    input  logic            ready_in
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam int              SUM_W   = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(FIFO_DEPTH);
    localparam logic [ARCH-1:0] STEP    = ARCH'(4);
    localparam logic [ARCH-1:0] ALIGN_M = ~ARCH'(3);

    logic             run_q;
    logic [ARCH-1:0]  req_pc_q, req_pc_d;
    logic [ARCH-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ARCH-1:0]  pc_buf_q    [FIFO_DEPTH];
    logic [ARCH-1:0]  instr_buf_q [FIFO_DEPTH];

    logic             grant;
    logic             push;
    logic             pop;
    logic             buf_nonempty;
    logic [SUM_W-1:0] credit_used;
    logic [ARCH-1:0]  redirect_pc;

    // Outstanding requests plus buffered words never exceed the buffer size,
    // so every response that is kept always finds a free FIFO slot.
    assign credit_used   = {1'b0, outstanding_q} + {1'b0, count_q};
    assign redirect_pc   = redirect_addr_in & ALIGN_M;
    assign buf_nonempty  = (count_q != '0);

    // run_q holds requests off until the first edge after reset release.
    assign imem_req_out  = run_q && !redirect_in && (credit_used < DEPTH_C);
    assign imem_addr_out = req_pc_q;
    assign valid_out     = buf_nonempty && !redirect_in;
    assign instr_out     = buf_nonempty ? instr_buf_q[rd_ptr_q] : '0;
    assign pc_out        = buf_nonempty ? pc_buf_q[rd_ptr_q]    : '0;

    assign grant = imem_req_out && imem_gnt_in;
    assign pop   = valid_out && ready_in;
    assign push  = imem_rvalid_in && !redirect_in && (discard_q == '0);

    // Next-state for PCs, credit/discard counters and FIFO pointers.
    always_comb begin
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid_in);
        discard_d     = discard_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (redirect_in) begin
            // Everything still in flight belongs to the old path; a response
            // landing in this very cycle is already accounted for here.
            req_pc_d  = redirect_pc;
            resp_pc_d = redirect_pc;
            discard_d = outstanding_q - CNT_W'(imem_rvalid_in);
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            if (grant) begin
                req_pc_d = req_pc_q + STEP;
            end
            if (imem_rvalid_in && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + STEP;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            run_q         <= 1'b0;
            req_pc_q      <= RESET_ADDR;
            resp_pc_q     <= RESET_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            run_q         <= 1'b1;
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only observed when count_q says they are valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_buf_q[wr_ptr_q]    <= resp_pc_q;
            instr_buf_q[wr_ptr_q] <= imem_rdata_in;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and random bench for instr_fetch with an in-order memory model and
// a scoreboard of expected {pc, instr} pairs filled at each grant.
module tb_instr_fetch;

    localparam logic [31:0] RST_A = 32'h0000_0000;

    logic        clk_in;
    logic        rstn_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in;

    instr_fetch #(.ARCH(32), .RESET_ADDR(RST_A), .FIFO_DEPTH(4)) dut (
        .clk_in           (clk_in),
        .rstn_in          (rstn_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_gnt_in      (imem_gnt_in),
        .imem_rvalid_in   (imem_rvalid_in),
        .imem_rdata_in    (imem_rdata_in),
        .redirect_in      (redirect_in),
        .redirect_addr_in (redirect_addr_in),
        .instr_out        (instr_out),
        .pc_out           (pc_out),
        .valid_out        (valid_out),
        .ready_in         (ready_in)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          grants = 0;
    int          xfers = 0;
    int          lat_fix = 1;
    bit          lat_rand = 0;
    bit          gnt_rand = 0;
    logic [31:0] req_exp = RST_A;
    pend_t       pend_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory model: drives grant and in-order responses shortly after each edge.
    initial begin
        imem_gnt_in    = 1'b1;
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = '0;
        forever begin
            @(posedge clk_in);
            cyc++;
            #1;
            imem_gnt_in = gnt_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
            if (rstn_in && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rvalid_in = 1'b1;
                imem_rdata_in  = fmem(pend_q[0].addr);
            end else begin
                imem_rvalid_in = 1'b0;
                imem_rdata_in  = '0;
            end
        end
    end

    // Mid-cycle sampler: memory bookkeeping, request-address model, scoreboard.
    always @(negedge clk_in) begin
        if (!rstn_in) begin
            pend_q.delete();
            exp_q.delete();
            req_exp = RST_A;
        end else begin
            if (imem_rvalid_in && pend_q.size() > 0) void'(pend_q.pop_front());
            if (imem_req_out && imem_gnt_in) begin
                pend_t p;
                chk("req_addr", imem_addr_out, req_exp);
                p.addr = imem_addr_out;
                p.due  = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_fix);
                pend_q.push_back(p);
                exp_q.push_back(req_exp);
                req_exp = req_exp + 32'd4;
                grants++;
            end
            if (redirect_in) begin
                exp_q.delete();
                req_exp = {redirect_addr_in[31:2], 2'b00};
            end
            if (valid_out && ready_in) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected_pc", pc_out, 32'hDEAD_DEAD);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("sb_pc", pc_out, e);
                    chk("sb_instr", instr_out, fmem(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          g0, x0, found, hit;
        logic [31:0] p0, i0;
        rstn_in          = 1'b0;
        ready_in         = 1'b1;
        redirect_in      = 1'b0;
        redirect_addr_in = '0;

        // Reset values
        repeat (3) @(negedge clk_in);
        chk("rst_req", imem_req_out, 0);
        chk("rst_addr", imem_addr_out, RST_A);
        chk("rst_valid", valid_out, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_pc", pc_out, 0);

        // Release; first request one cycle later, pc 0 delivered two after that
        @(posedge clk_in); #1 rstn_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        chk("first_req", imem_req_out, 1);
        chk("first_addr", imem_addr_out, RST_A);
        @(negedge clk_in);
        chk("lat_c1_valid", valid_out, 0);
        @(negedge clk_in);
        chk("lat_c2_valid", valid_out, 1);
        chk("lat_c2_pc", pc_out, RST_A);
        chk("lat_c2_instr", instr_out, fmem(RST_A));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            chk("stream_nogap", valid_out, 1);
        end

        // Backpressure for 10+ cycles
        @(posedge clk_in); #1 ready_in = 1'b0;
        g0 = grants;
        @(negedge clk_in);
        p0 = pc_out;
        i0 = instr_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("bp_pc_stable", pc_out, p0);
            chk("bp_instr_stable", instr_out, i0);
        end
        chk("bp_grants_le4", (grants - g0) <= 4, 1);
        chk("bp_full_noreq", imem_req_out, 0);
        chk("bp_full_valid", valid_out, 1);
        @(posedge clk_in); #1 ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            chk("bp_release_nogap", valid_out, 1);
        end

        // Redirect with responses in flight (2-cycle memory), unaligned target
        @(posedge clk_in); #1 lat_fix = 2;
        repeat (6) @(negedge clk_in);
        @(posedge clk_in); #1 redirect_in = 1'b1; redirect_addr_in = 32'h0000_0103;
        @(negedge clk_in);
        chk("redir_valid_low", valid_out, 0);
        chk("redir_req_low", imem_req_out, 0);
        @(posedge clk_in); #1 redirect_in = 1'b0;
        @(negedge clk_in);
        chk("redir_req", imem_req_out, 1);
        chk("redir_addr", imem_addr_out, 32'h0000_0100);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_out) begin
                found = 1;
                break;
            end
            @(negedge clk_in);
        end
        chk("redir_delivered", found, 1);
        chk("redir_first_pc", pc_out, 32'h0000_0100);
        chk("redir_first_instr", instr_out, fmem(32'h0000_0100));

        // Redirect coinciding with a response, one outstanding, zero-wait memory
        @(posedge clk_in); #1 lat_fix = 1;
        repeat (6) @(negedge clk_in);
        @(posedge clk_in); #1 redirect_in = 1'b1; redirect_addr_in = 32'h0000_0200;
        @(negedge clk_in);
        chk("redir2_rvalid_same_cycle", imem_rvalid_in, 1);
        chk("redir2_valid_low", valid_out, 0);
        @(posedge clk_in); #1 redirect_in = 1'b0;
        @(negedge clk_in);
        chk("redir2_r1_addr", imem_addr_out, 32'h0000_0200);
        chk("redir2_r1_valid", valid_out, 0);
        @(negedge clk_in);
        chk("redir2_r2_valid", valid_out, 0);
        @(negedge clk_in);
        chk("redir2_r3_valid", valid_out, 1);
        chk("redir2_r3_pc", pc_out, 32'h0000_0200);

        // Address wrap-around
        @(posedge clk_in); #1 redirect_in = 1'b1; redirect_addr_in = 32'hFFFF_FFF8;
        @(posedge clk_in); #1 redirect_in = 1'b0;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (valid_out && pc_out == 32'h0) hit = 1;
        end
        chk("wrap_pc_zero_seen", hit, 1);

        // Random grant stalls, 1-3 cycle latency, random ready
        @(posedge clk_in); #1 gnt_rand = 1; lat_rand = 1;
        x0 = xfers;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk_in); #1 ready_in = ($urandom_range(0, 3) != 0);
            @(negedge clk_in);
            if (xfers - x0 >= 1000) break;
        end
        chk("random_1000_delivered", (xfers - x0) >= 1000, 1);
        @(posedge clk_in); #1 gnt_rand = 0; lat_rand = 0; lat_fix = 1; ready_in = 1'b1;
        repeat (8) @(negedge clk_in);

        // Reset mid-stream with a full buffer
        @(posedge clk_in); #1 ready_in = 1'b0;
        repeat (8) @(negedge clk_in);
        chk("pre_rst_full_valid", valid_out, 1);
        chk("pre_rst_full_noreq", imem_req_out, 0);
        @(posedge clk_in); #1 rstn_in = 1'b0;
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_req", imem_req_out, 0);
        chk("midrst_pc", pc_out, 0);
        repeat (2) @(negedge clk_in);
        @(posedge clk_in); #1 rstn_in = 1'b1; ready_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        chk("post_rst_req", imem_req_out, 1);
        chk("post_rst_addr", imem_addr_out, RST_A);
        repeat (10) @(negedge clk_in);
        chk("post_rst_streaming", valid_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
